// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI read arbiter.
// Per-port state encoding and AR field helpers.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } port_state_t;

  localparam logic [2:0] RD_TYPE_LINE   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic logic [2:0] ar_size(
    input logic [2:0] rd_type
  );
    return (rd_type == RD_TYPE_LINE) ?
      3'b010 : {1'b0, rd_type[1:0]};
  endfunction

endpackage

// File: rtl/axi_rd_if.sv
// AXI read-address and read-data channel bundle.
// master drives AR and rready; slave drives arready and R.
interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize,
    output arburst, arlock, arcache, arprot,
    output arvalid, rready,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize,
    input  arburst, arlock, arcache, arprot,
    input  arvalid, rready,
    output arready,
    output rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_port_fsm.sv
// Per-requester read state and return routing.
// Tracks one outstanding read and steers beats tagged with ID.
module axi_rd_port_fsm
  import axi_pkg::*;
#(
  parameter logic [3:0] ID = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
  input  logic       ar_hs,
  input  logic [3:0] arid,
  input  logic       rvalid,
  input  logic [3:0] rid,
  input  logic       rlast,
  output logic       idle,
  output logic       ret_valid
);

  port_state_t state, state_n;

  assign idle      = (state == IDLE);
  assign ret_valid = rvalid & (rid == ID)
                   & (state == DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = ADDR;
      ADDR: if (ar_hs && arid == ID)
              state_n = DATA;
      DATA: if (ret_valid && rlast)
              state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between I-cache and D-cache.
// Round-robin grant into a single AR slot; returns routed by rid.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter logic [3:0] ID_I     = 4'd0,
  parameter logic [3:0] ID_D     = 4'd1,
  parameter logic [7:0] LINE_LEN = 8'd3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_rd_req,
  input  logic [2:0]  i_rd_type,
  input  logic [31:0] i_rd_addr,
  output logic        i_rd_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic [31:0] i_ret_data,
  input  logic        d_rd_req,
  input  logic [2:0]  d_rd_type,
  input  logic [31:0] d_rd_addr,
  output logic        d_rd_rdy,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] d_ret_data,
  axi_rd_if.master    axi,
  output logic        err_rid
);

  logic        ar_valid;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size_q;
  logic        fav_i;
  logic        i_idle, d_idle;
  logic        i_v, d_v, gnt_i, gnt_d;
  logic        ar_hs, acc;
  logic [2:0]  sel_type;

  assign ar_hs = ar_valid & axi.arready;
  assign i_v   = i_rd_req & i_idle;
  assign d_v   = d_rd_req & d_idle;
  // fav_i clear after reset: D wins the first tie
  assign gnt_i = i_v & (~d_v | fav_i);
  assign gnt_d = d_v & (~i_v | ~fav_i);

  assign i_rd_rdy = ~ar_valid & gnt_i;
  assign d_rd_rdy = ~ar_valid & gnt_d;
  assign acc      = i_rd_rdy | d_rd_rdy;
  assign sel_type = d_rd_rdy ? d_rd_type : i_rd_type;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_valid  <= 1'b0;
      ar_id     <= 4'd0;
      ar_addr   <= 32'd0;
      ar_len    <= 8'd0;
      ar_size_q <= 3'd0;
      fav_i     <= 1'b0;
      err_rid   <= 1'b0;
    end else begin
      if (acc) begin
        ar_valid  <= 1'b1;
        ar_id     <= d_rd_rdy ? ID_D : ID_I;
        ar_addr   <= d_rd_rdy ? d_rd_addr : i_rd_addr;
        ar_len    <= (sel_type == RD_TYPE_LINE) ?
                     LINE_LEN : 8'd0;
        ar_size_q <= ar_size(sel_type);
        fav_i     <= d_rd_rdy;
      end else if (ar_hs) begin
        ar_valid <= 1'b0;
      end
      if (axi.rvalid & ~i_ret_valid & ~d_ret_valid)
        err_rid <= 1'b1;
    end
  end

  axi_rd_port_fsm #(.ID(ID_I)) u_port_i (
    .clk       (aclk),
    .rst_n     (aresetn),
    .accept    (i_rd_rdy),
    .ar_hs     (ar_hs),
    .arid      (ar_id),
    .rvalid    (axi.rvalid),
    .rid       (axi.rid),
    .rlast     (axi.rlast),
    .idle      (i_idle),
    .ret_valid (i_ret_valid)
  );

  axi_rd_port_fsm #(.ID(ID_D)) u_port_d (
    .clk       (aclk),
    .rst_n     (aresetn),
    .accept    (d_rd_rdy),
    .ar_hs     (ar_hs),
    .arid      (ar_id),
    .rvalid    (axi.rvalid),
    .rid       (axi.rid),
    .rlast     (axi.rlast),
    .idle      (d_idle),
    .ret_valid (d_ret_valid)
  );

  assign i_ret_last  = axi.rlast;
  assign i_ret_data  = axi.rdata;
  assign d_ret_last  = axi.rlast;
  assign d_ret_data  = axi.rdata;

  assign axi.arvalid = ar_valid;
  assign axi.arid    = ar_id;
  assign axi.araddr  = ar_addr;
  assign axi.arlen   = ar_len;
  assign axi.arsize  = ar_size_q;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.rready  = 1'b1;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter.
// Inputs change 2ns after posedge; checks land before the next edge.
module tb_axi_rd_arbiter;

  logic        aclk;
  logic        aresetn;
  logic        i_rd_req, d_rd_req;
  logic [2:0]  i_rd_type, d_rd_type;
  logic [31:0] i_rd_addr, d_rd_addr;
  logic        i_rd_rdy, i_ret_valid, i_ret_last;
  logic [31:0] i_ret_data;
  logic        d_rd_rdy, d_ret_valid, d_ret_last;
  logic [31:0] d_ret_data;
  logic        err_rid;
  int          n_run, n_fail;

  axi_rd_if axi ();

  axi_rd_arbiter dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_rd_req    (i_rd_req),
    .i_rd_type   (i_rd_type),
    .i_rd_addr   (i_rd_addr),
    .i_rd_rdy    (i_rd_rdy),
    .i_ret_valid (i_ret_valid),
    .i_ret_last  (i_ret_last),
    .i_ret_data  (i_ret_data),
    .d_rd_req    (d_rd_req),
    .d_rd_type   (d_rd_type),
    .d_rd_addr   (d_rd_addr),
    .d_rd_rdy    (d_rd_rdy),
    .d_ret_valid (d_ret_valid),
    .d_ret_last  (d_ret_last),
    .d_ret_data  (d_ret_data),
    .axi         (axi),
    .err_rid     (err_rid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #2;
  endtask

  logic [3:0] rids [5];
  logic       lasts[5];

  initial begin
    n_run = 0;
    n_fail = 0;
    aresetn = 1'b0;
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = 0;
    axi.rdata = 0; axi.rlast = 0; axi.rresp = 0;
    #12;
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_araddr", axi.araddr, 0);
    check("rst_arlen", axi.arlen, 0);
    check("rst_rready", axi.rready, 1);
    check("rst_err", err_rid, 0);
    check("rst_irdy", i_rd_rdy, 0);
    check("rst_drdy", d_rd_rdy, 0);
    aresetn = 1'b1;
    tick();

    // single I line read
    i_rd_req = 1; i_rd_type = 3'b100;
    i_rd_addr = 32'h1C00_0010;
    #1 check("i_rdy", i_rd_rdy, 1);
    tick();
    i_rd_req = 0;
    #1;
    check("i_arvalid", axi.arvalid, 1);
    check("i_arid", axi.arid, 0);
    check("i_arlen", axi.arlen, 3);
    check("i_arsize", axi.arsize, 2);
    check("i_araddr", axi.araddr, 32'h1C00_0010);
    check("i_arburst", axi.arburst, 1);
    tick();
    tick();
    axi.arready = 1;
    tick();
    axi.arready = 0;
    #1 check("i_ar_clr", axi.arvalid, 0);
    for (int k = 0; k < 4; k++) begin
      axi.rvalid = 1; axi.rid = 0;
      axi.rdata = 32'hA0 + k;
      axi.rlast = (k == 3);
      #1;
      check("i_rv", i_ret_valid, 1);
      check("i_rdata", i_ret_data, 32'hA0 + k);
      check("i_rlast", i_ret_last, (k == 3));
      check("i_no_d", d_ret_valid, 0);
      tick();
    end
    axi.rvalid = 0; axi.rlast = 0;
    i_rd_req = 1;
    #1 check("i_idle_again", i_rd_rdy, 1);
    check("i_err", err_rid, 0);
    i_rd_req = 0;

    // simultaneous requests right after reset
    aresetn = 0;
    #1 aresetn = 1;
    tick();
    i_rd_req = 1; i_rd_type = 3'b100;
    i_rd_addr = 32'h1C00_0100;
    d_rd_req = 1; d_rd_type = 3'b010;
    d_rd_addr = 32'h0000_1000;
    #1;
    check("tie_d_rdy", d_rd_rdy, 1);
    check("tie_i_rdy", i_rd_rdy, 0);
    tick();
    d_rd_req = 0;
    #1;
    check("tie_arid_d", axi.arid, 1);
    check("tie_d_arlen", axi.arlen, 0);
    check("tie_d_arsize", axi.arsize, 2);
    check("tie_i_busy", i_rd_rdy, 0);
    axi.arready = 1;
    #1 check("no_passthru", i_rd_rdy, 0);
    tick();
    axi.arready = 0;
    #1 check("i_after_hs", i_rd_rdy, 1);
    tick();
    i_rd_req = 0;
    #1;
    check("tie_arid_i", axi.arid, 0);
    check("tie_i_arlen", axi.arlen, 3);
    axi.arready = 1;
    tick();
    axi.arready = 0;

    // interleaved returns, rid 0,1,0,0,0
    rids  = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    lasts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      axi.rvalid = 1; axi.rid = rids[k];
      axi.rlast = lasts[k];
      axi.rdata = 32'hB0 + k;
      #1;
      check("il_i", i_ret_valid, rids[k] == 0);
      check("il_d", d_ret_valid, rids[k] == 1);
      check("il_dd", d_ret_data, 32'hB0 + k);
      tick();
    end
    axi.rvalid = 0; axi.rlast = 0;
    #1 check("il_err", err_rid, 0);

    // D byte read
    d_rd_req = 1; d_rd_type = 3'b000;
    d_rd_addr = 32'h8000_0003;
    #1 check("b_rdy", d_rd_rdy, 1);
    tick();
    d_rd_req = 0;
    #1;
    check("b_arlen", axi.arlen, 0);
    check("b_arsize", axi.arsize, 0);
    check("b_araddr", axi.araddr, 32'h8000_0003);
    axi.arready = 1;
    tick();
    axi.arready = 0;
    axi.rvalid = 1; axi.rid = 1;
    axi.rlast = 1; axi.rdata = 32'hCC;
    #1;
    check("b_rv", d_ret_valid, 1);
    check("b_last", d_ret_last, 1);
    tick();
    axi.rvalid = 0; axi.rlast = 0;

    // next tie: D was granted last, I wins
    i_rd_req = 1; i_rd_type = 3'b010;
    i_rd_addr = 32'h1C00_0200;
    d_rd_req = 1; d_rd_type = 3'b010;
    d_rd_addr = 32'h0000_2000;
    #1;
    check("tie2_i", i_rd_rdy, 1);
    check("tie2_d", d_rd_rdy, 0);
    tick();
    i_rd_req = 0;

    // arready held low for 10 cycles
    for (int k = 0; k < 10; k++) begin
      #1;
      check("hold_v", axi.arvalid, 1);
      check("hold_addr", axi.araddr, 32'h1C00_0200);
      check("hold_id", axi.arid, 0);
      check("hold_drdy", d_rd_rdy, 0);
      tick();
    end
    d_rd_req = 0;
    axi.arready = 1;
    tick();
    axi.arready = 0;

    // stray beat for idle D
    axi.rvalid = 1; axi.rid = 1;
    axi.rlast = 1; axi.rdata = 32'hDD;
    #1;
    check("stray_d", d_ret_valid, 0);
    check("stray_i", i_ret_valid, 0);
    tick();
    axi.rvalid = 0; axi.rlast = 0;
    #1 check("stray_err", err_rid, 1);

    // reset mid-burst with AR pending
    d_rd_req = 1; d_rd_type = 3'b100;
    d_rd_addr = 32'h0000_3000;
    tick();
    d_rd_req = 0;
    axi.rvalid = 1; axi.rid = 0;
    axi.rlast = 0; axi.rdata = 32'hEE;
    #1 check("mid_rv", i_ret_valid, 1);
    aresetn = 0;
    #1;
    check("ar_arvalid", axi.arvalid, 0);
    check("ar_araddr", axi.araddr, 0);
    check("ar_arid", axi.arid, 0);
    check("ar_arlen", axi.arlen, 0);
    check("ar_err", err_rid, 0);
    check("ar_irv", i_ret_valid, 0);
    check("ar_drdy", d_rd_rdy, 0);
    axi.rvalid = 0;
    aresetn = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
